chk_event_collector: RTL and testbench

Collects failure and pass pulses from up to NUM_CHK assertion checker instances. The checkers are the producers; this block consumes their pulses.
- Keeps saturating per-checker fail and pass counters.
- Timestamps each failure and queues a record (checker id, timestamp) in a FIFO.
- A downstream logger drains the FIFO over a valid/ready interface.
- Sits between the checker bank and the debug/status register file.

---
 rtl/chk_event_collector.sv | 135 +++++++++++++
 tb/tb_chk_event_collector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chk_event_collector.sv
// Event collector for a bank of assertion checkers: saturating pass/fail counters per
// lane plus a timestamped failure-record FIFO drained by a logger over valid/ready.
module chk_event_collector #(
   parameter  int NUM_CHK = 4,
   parameter  int CNT_W   = 16,
   parameter  int TS_W    = 16,
   parameter  int DEPTH   = 8,
   localparam int IW      = $clog2(NUM_CHK),
   localparam int LW      = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CHK-1:0]       fail_i,
   input  logic [NUM_CHK-1:0]       pass_i,
   input  logic                     clear_i,
   output logic                     rec_valid_o,
   input  logic                     rec_ready_i,
   output logic [IW-1:0]            rec_id_o,
   output logic [TS_W-1:0]          rec_ts_o,
   output logic [NUM_CHK*CNT_W-1:0] fail_cnt_o,
   output logic [NUM_CHK*CNT_W-1:0] pass_cnt_o,
   output logic [LW-1:0]            level_o,
   output logic                     any_fail_o,
   output logic                     overflow_o
);

   localparam int PW = LW - 1;

   logic [TS_W-1:0]    ts;
   logic [CNT_W-1:0]   fail_cnt [NUM_CHK];
   logic [CNT_W-1:0]   pass_cnt [NUM_CHK];
   logic [NUM_CHK-1:0] pending;
   logic [TS_W-1:0]    pts      [NUM_CHK];
   logic [IW-1:0]      mem_id   [DEPTH];
   logic [TS_W-1:0]    mem_ts   [DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [LW-1:0]      level;
   logic               any_fail, overflow;
   logic               pop, push, has_win;
   logic [IW-1:0]      win;

   // Lowest-index pending lane wins; scanning downward lets the last hit be the lowest.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      has_win = 1'b0;
      win     = '0;
      for (int k = NUM_CHK - 1; k >= 0; k--) begin
         if (pending[k]) begin
            has_win = 1'b1;
            win     = IW'(k);
         end
      end
   end

   assign rec_valid_o = (level != '0);
   assign pop         = rec_valid_o && rec_ready_i;
   assign push        = has_win && ((level < LW'(DEPTH)) || pop);

   // Head fields read as zero when empty, since the storage itself is never reset.
   assign rec_id_o    = rec_valid_o ? mem_id[rd_ptr] : '0;
   assign rec_ts_o    = rec_valid_o ? mem_ts[rd_ptr] : '0;
   assign level_o     = level;
   assign any_fail_o  = any_fail;
   assign overflow_o  = overflow;

   for (genvar k = 0; k < NUM_CHK; k++) begin : g_pack
      assign fail_cnt_o[k*CNT_W +: CNT_W] = fail_cnt[k];
      assign pass_cnt_o[k*CNT_W +: CNT_W] = pass_cnt[k];
   end

   // NOTE: record storage has no reset; validity is tracked by level, so stale data is never seen.
   always_ff @(posedge clk) begin
      if (push && !clear_i) begin
         mem_id[wr_ptr] <= win;
         mem_ts[wr_ptr] <= pts[win];
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every lane sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts       <= '0;
         pending  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         any_fail <= 1'b0;
         overflow <= 1'b0;
         for (int k = 0; k < NUM_CHK; k++) begin
            fail_cnt[k] <= '0;
            pass_cnt[k] <= '0;
            pts[k]      <= '0;
         end
      end else if (clear_i) begin
         ts       <= '0;
         pending  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         any_fail <= 1'b0;
         overflow <= 1'b0;
         for (int k = 0; k < NUM_CHK; k++) begin
            fail_cnt[k] <= '0;
            pass_cnt[k] <= '0;
            pts[k]      <= '0;
         end
      end else begin
         ts <= ts + TS_W'(1);
         if (|fail_i) any_fail <= 1'b1;
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);

         for (int k = 0; k < NUM_CHK; k++) begin
            if (fail_i[k] && fail_cnt[k] != '1) fail_cnt[k] <= fail_cnt[k] + CNT_W'(1);
            if (pass_i[k] && pass_cnt[k] != '1) pass_cnt[k] <= pass_cnt[k] + CNT_W'(1);

            // A fail arriving as the lane drains re-arms it with a fresh timestamp.
            if (push && win == IW'(k)) begin
               pending[k] <= fail_i[k];
               if (fail_i[k]) pts[k] <= ts;
            end else if (fail_i[k]) begin
               if (pending[k]) begin
                  overflow <= 1'b1;
               end else begin
                  pending[k] <= 1'b1;
                  pts[k]     <= ts;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_chk_event_collector.sv
// Directed and random checks of chk_event_collector against a queue-based model
// of the record-collection rules.
module tb_chk_event_collector;

   localparam int N  = 4;
   localparam int CW = 4;
   localparam int TW = 16;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [N-1:0]  fail = '0;
   logic [N-1:0]  pass = '0;
   logic          clear = 1'b0;
   logic          ready = 1'b0;
   logic          rec_valid;
   logic [1:0]    rec_id;
   logic [TW-1:0] rec_ts;
   logic [N*CW-1:0] fail_cnt, pass_cnt;
   logic [3:0]    level;
   logic          any_fail, overflow;

   int n_assert = 0;
   int n_fail   = 0;

   chk_event_collector #(.NUM_CHK(N), .CNT_W(CW), .TS_W(TW), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .fail_i(fail), .pass_i(pass), .clear_i(clear),
      .rec_valid_o(rec_valid), .rec_ready_i(ready), .rec_id_o(rec_id), .rec_ts_o(rec_ts),
      .fail_cnt_o(fail_cnt), .pass_cnt_o(pass_cnt), .level_o(level),
      .any_fail_o(any_fail), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   // Reference model: records held in a queue, lanes as plain integers.
   typedef struct { int id; int ts; } rec_t;
   rec_t m_q[$];
   int   m_ts;
   int   m_fcnt [N];
   int   m_pcnt [N];
   bit   m_pend [N];
   int   m_pts  [N];
   bit   m_any, m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      m_q.delete();
      m_ts = 0; m_any = 0; m_ovf = 0;
      for (int k = 0; k < N; k++) begin
         m_fcnt[k] = 0; m_pcnt[k] = 0; m_pend[k] = 0; m_pts[k] = 0;
      end
   endtask

   task automatic model_update();
      bit   do_pop, do_push;
      int   w;
      rec_t r;
      if (!rst_n || clear) begin
         reset_model();
         return;
      end
      do_pop = (m_q.size() != 0) && ready;
      w = -1;
      for (int k = N - 1; k >= 0; k--) if (m_pend[k]) w = k;
      do_push = (w >= 0) && (m_q.size() < D || do_pop);
      if (do_push) begin
         r.id = w;
         r.ts = m_pts[w];
      end
      for (int k = 0; k < N; k++) begin
         if (do_push && k == w) begin
            m_pend[k] = fail[k];
            if (fail[k]) m_pts[k] = m_ts;
         end else if (fail[k]) begin
            if (m_pend[k]) m_ovf = 1;
            else begin m_pend[k] = 1; m_pts[k] = m_ts; end
         end
         if (fail[k] && m_fcnt[k] < (1 << CW) - 1) m_fcnt[k]++;
         if (pass[k] && m_pcnt[k] < (1 << CW) - 1) m_pcnt[k]++;
      end
      if (fail != '0) m_any = 1;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(r);
      m_ts = (m_ts + 1) % (1 << TW);
   endtask

   task automatic check_all();
      bit ne;
      ne = (m_q.size() != 0);
      chk("rec_valid", 32'(rec_valid), 32'(ne));
      chk("rec_id",    32'(rec_id),    ne ? m_q[0].id : 0);
      chk("rec_ts",    32'(rec_ts),    ne ? m_q[0].ts : 0);
      chk("level",     32'(level),     m_q.size());
      chk("any_fail",  32'(any_fail),  32'(m_any));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      for (int k = 0; k < N; k++) begin
         chk($sformatf("fail_cnt[%0d]", k), 32'(fail_cnt[k*CW +: CW]), m_fcnt[k]);
         chk($sformatf("pass_cnt[%0d]", k), 32'(pass_cnt[k*CW +: CW]), m_pcnt[k]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 200 && m_ts != target; i++) step();
   endtask

   task automatic do_clear();
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".rec_valid"}, 32'(rec_valid), 0);
      chk({tag, ".rec_id"},    32'(rec_id),    0);
      chk({tag, ".rec_ts"},    32'(rec_ts),    0);
      chk({tag, ".level"},     32'(level),     0);
      chk({tag, ".fail_cnt"},  32'(fail_cnt),  0);
      chk({tag, ".pass_cnt"},  32'(pass_cnt),  0);
      chk({tag, ".any_fail"},  32'(any_fail),  0);
      chk({tag, ".overflow"},  32'(overflow),  0);
   endtask

   initial begin
      int last_id, last_ts, n_pop, n_lane1;
      reset_model();

      // Power-on reset
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("reset");
      step(); step();
      #3 rst_n = 1'b1;

      // Single fail on lane 2 at ts=5
      run_to(5);
      fail = 4'b0100; step(); fail = '0; step();
      chk("single.valid", 32'(rec_valid), 1);
      chk("single.id",    32'(rec_id),    2);
      chk("single.ts",    32'(rec_ts),    5);
      chk("single.cnt2",  32'(fail_cnt[2*CW +: CW]), 1);
      chk("single.any",   32'(any_fail),  1);
      ready = 1'b1; step(); ready = 1'b0;
      chk("single.level", 32'(level), 0);

      // Simultaneous fails on lanes 0,1,3 at ts=10
      do_clear();
      run_to(10);
      fail = 4'b1011; step(); fail = '0;
      step(); step(); step();
      chk("simul.level", 32'(level),    3);
      chk("simul.ovf",   32'(overflow), 0);
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("simul.id%0d", i), 32'(rec_id), (i == 2) ? 3 : i);
         chk($sformatf("simul.ts%0d", i), 32'(rec_ts), 10);
         step();
      end
      ready = 1'b0;
      chk("simul.empty", 32'(level), 0);

      // Backpressure: nine lane-0 pulses two cycles apart into a full FIFO
      do_clear();
      for (int i = 0; i < 9; i++) begin
         fail = 4'b0001; step(); fail = '0; step();
      end
      step(); step();
      chk("bp.level", 32'(level),    8);
      chk("bp.ovf",   32'(overflow), 0);
      ready = 1'b1; step(); ready = 1'b0;
      chk("bp.refill", 32'(level), 8);
      ready = 1'b1;
      n_pop = 0;
      while (rec_valid && n_pop < 20) begin
         chk($sformatf("bp.ts%0d", n_pop), 32'(rec_ts), 2 * (n_pop + 1));
         last_id = rec_id; last_ts = rec_ts;
         step(); n_pop++;
      end
      ready = 1'b0;
      chk("bp.drained", 32'(rec_valid), 0);
      chk("bp.last_id", 32'(last_id), 0);
      chk("bp.last_ts", 32'(last_ts), 16);

      // Overflow: full FIFO, lane 1 pulsed twice
      do_clear();
      fail = 4'b0001; repeat (8) step(); fail = '0;
      step(); step();
      chk("ovf.full", 32'(level), 8);
      fail = 4'b0010; step(); fail = '0; step();
      fail = 4'b0010; step(); fail = '0; step();
      chk("ovf.flag", 32'(overflow), 1);
      chk("ovf.cnt1", 32'(fail_cnt[1*CW +: CW]), 2);
      chk("ovf.cnt0", 32'(fail_cnt[0*CW +: CW]), 8);
      ready = 1'b1;
      n_pop = 0; n_lane1 = 0;
      while (rec_valid && n_pop < 30) begin
         if (rec_id == 2'd1) n_lane1++;
         step(); n_pop++;
      end
      ready = 1'b0;
      chk("ovf.drained", 32'(rec_valid), 0);
      chk("ovf.lane1_recs", 32'(n_lane1), 1);

      // Saturation then clear (with pulses in the clear cycle ignored)
      fail = 4'b0001; step(); fail = '0; step(); step();
      pass = 4'b1000; repeat (20) step(); pass = '0;
      chk("sat.pass3", 32'(pass_cnt[3*CW +: CW]), 15);
      fail = 4'b1111; pass = 4'b1111;
      do_clear();
      fail = '0; pass = '0;
      chk_reset_outputs("clear");
      fail = 4'b0001; step(); fail = '0; step(); step();
      chk("clear.ts0", 32'(rec_ts), 0);
      chk("clear.id0", 32'(rec_id), 0);

      // Async reset between edges with three records queued
      fail = 4'b0110; step(); fail = '0; step(); step(); step();
      chk("arst.level", 32'(level), 3);
      #3 rst_n = 1'b0;
      #1 chk_reset_outputs("arst");
      reset_model();
      step(); step();
      #3 rst_n = 1'b1;

      // Random traffic with occasional clears
      for (int i = 0; i < 800; i++) begin
         fail  = N'($urandom & $urandom & $urandom);
         pass  = N'($urandom);
         ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
         clear = ($urandom_range(0, 149) == 0);
         step();
      end
      fail = '0; pass = '0; clear = 1'b0; ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
